// File: rtl/multicycle_controller.sv
// Multicycle RISC control unit: Moore FSM stepping fetch/decode/execute/memory/writeback
// with a mem_ready handshake and a wait-state timeout on memory states.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               memwrite,
  output logic               iord,
  output logic               irwrite,
  output logic               pcen,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic               illegal_op,
  output logic               bus_err,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic             mem_phase;
  logic             timeout;
  logic             decode_bad;
  logic             illegal_q;
  logic             bus_err_q;
  logic             pcwrite;
  logic             branch;

  // Next-state, timeout detection and wait-counter update
  always_comb begin
    nxt        = cur;
    mem_phase  = 1'b0;
    decode_bad = 1'b0;
    case (cur)
      FETCH: begin
        mem_phase = 1'b1;
        if (mem_ready) nxt = DECODE;
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = EXECUTE;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default: begin
            nxt        = FETCH;
            decode_bad = 1'b1;
          end
        endcase
      end
      MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        mem_phase = 1'b1;
        if (mem_ready) nxt = MEMWB;
      end
      MEMWB:   nxt = FETCH;
      MEMWR: begin
        mem_phase = 1'b1;
        if (mem_ready) nxt = FETCH;
      end
      EXECUTE: nxt = ALUWB;
      ALUWB:   nxt = FETCH;
      BRANCH:  nxt = FETCH;
      ADDIEX:  nxt = ADDIWB;
      ADDIWB:  nxt = FETCH;
      JUMP:    nxt = FETCH;
      default: nxt = FETCH;
    endcase

    // A completing access on the last allowed cycle is not a timeout
    timeout = (TIMEOUT != 0) && mem_phase && !mem_ready &&
              (wait_cnt == CNT_W'(TIMEOUT - 1));
    if (timeout) nxt = FETCH;

    if (timeout || (nxt != cur) || !mem_phase || mem_ready)
      wait_nxt = '0;
    else
      wait_nxt = wait_cnt + CNT_W'(1);
  end

  // State, wait counter and error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      cur       <= nxt;
      wait_cnt  <= wait_nxt;
      illegal_q <= decode_bad;
      bus_err_q <= timeout;
    end
  end

  // Moore output decode; everything held low while reset is asserted
  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    pcen       = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    state      = '0;
    if (rst_n) begin
      case (cur)
        FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        DECODE:  alusrcb = 2'b11;
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        EXECUTE: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        BRANCH: begin
          alusrca = 1'b1;
          aluop   = 2'b01;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        ADDIWB:  regwrite = 1'b1;
        JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
      pcen       = pcwrite | (branch & zero);
      illegal_op = illegal_q;
      bus_err    = bus_err_q;
      state      = STATE_W'(cur);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle vector bench for multicycle_controller with a scoreboard queue.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg;
  logic       alusrca, illegal_op, bus_err;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  multicycle_controller #(.TIMEOUT(16), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .illegal_op(illegal_op), .bus_err(bus_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  // ctl = {mem_req, memwrite, irwrite, pcen, regwrite, illegal_op, bus_err}
  localparam logic [6:0] C0    = 7'b0000000;
  localparam logic [6:0] C_FOK = 7'b1011000;
  localparam logic [6:0] C_MW  = 7'b1000000;
  localparam logic [6:0] C_WR  = 7'b1100000;
  localparam logic [6:0] C_WB  = 7'b0000100;
  localparam logic [6:0] C_PC  = 7'b0001000;
  localparam logic [6:0] C_ILL = 7'b0000010;
  localparam logic [6:0] C_BUS = 7'b0000001;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       rdy;
    logic [3:0] st;
    logic [6:0] ctl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Mux selects per state: {iord, regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop}
  function automatic logic [9:0] mux_exp(input logic [3:0] s);
    case (s)
      4'd0:    return 10'b0000_01_00_00;
      4'd1:    return 10'b0000_11_00_00;
      4'd2:    return 10'b0001_10_00_00;
      4'd3:    return 10'b1000_00_00_00;
      4'd4:    return 10'b0010_00_00_00;
      4'd5:    return 10'b1000_00_00_00;
      4'd6:    return 10'b0001_00_00_10;
      4'd7:    return 10'b0100_00_00_00;
      4'd8:    return 10'b0001_00_01_01;
      4'd9:    return 10'b0001_10_00_00;
      4'd11:   return 10'b0000_00_10_00;
      default: return 10'b0000_00_00_00;
    endcase
  endfunction

  task automatic add(input string name, input logic rst, input logic [5:0] o,
                     input logic z, input logic r, input logic [3:0] s,
                     input logic [6:0] c, input int n = 1);
    vec_t v;
    v.name = name; v.rst = rst; v.op = o; v.zero = z; v.rdy = r; v.st = s; v.ctl = c;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string what, input string name, input int idx,
                       input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s @vec %0d: got %b expected %b", what, name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    logic [9:0] mux_e;
    rst_n = 1'b0; op = RT; zero = 1'b0; mem_ready = 1'b0;

    add("reset",      0, RT,   0, 1, 4'd0,  C0, 3);
    add("lw_fetch",   1, LW,   0, 1, 4'd0,  C_FOK);
    add("lw_dec",     1, LW,   0, 1, 4'd1,  C0);
    add("lw_adr",     1, LW,   0, 1, 4'd2,  C0);
    add("lw_rd",      1, LW,   0, 1, 4'd3,  C_MW);
    add("lw_wb",      1, LW,   0, 1, 4'd4,  C_WB);
    add("r_fetch",    1, RT,   0, 1, 4'd0,  C_FOK);
    add("r_dec",      1, RT,   0, 1, 4'd1,  C0);
    add("r_exe",      1, RT,   0, 1, 4'd6,  C0);
    add("r_wb",       1, RT,   0, 1, 4'd7,  C_WB);
    add("beq1_fetch", 1, BEQ,  1, 1, 4'd0,  C_FOK);
    add("beq1_dec",   1, BEQ,  1, 1, 4'd1,  C0);
    add("beq1_br",    1, BEQ,  1, 1, 4'd8,  C_PC);
    add("beq0_fetch", 1, BEQ,  0, 1, 4'd0,  C_FOK);
    add("beq0_dec",   1, BEQ,  0, 1, 4'd1,  C0);
    add("beq0_br",    1, BEQ,  0, 1, 4'd8,  C0);
    add("addi_fetch", 1, ADDI, 0, 1, 4'd0,  C_FOK);
    add("addi_dec",   1, ADDI, 0, 1, 4'd1,  C0);
    add("addi_ex",    1, ADDI, 0, 1, 4'd9,  C0);
    add("addi_wb",    1, ADDI, 0, 1, 4'd10, C_WB);
    add("j_fetch",    1, J,    0, 1, 4'd0,  C_FOK);
    add("j_dec",      1, J,    0, 1, 4'd1,  C0);
    add("j_jump",     1, J,    0, 1, 4'd11, C_PC);
    add("sw_fetch",   1, SW,   0, 1, 4'd0,  C_FOK);
    add("sw_dec",     1, SW,   0, 1, 4'd1,  C0);
    add("sw_adr",     1, SW,   0, 1, 4'd2,  C0);
    add("sw_wait",    1, SW,   0, 0, 4'd5,  C_WR, 3);
    add("sw_done",    1, SW,   0, 1, 4'd5,  C_WR);
    add("ill_fetch",  1, BAD,  0, 1, 4'd0,  C_FOK);
    add("ill_dec",    1, BAD,  0, 1, 4'd1,  C0);
    add("ill_pulse",  1, BAD,  0, 0, 4'd0,  C_MW | C_ILL);
    add("fetch_wait", 1, J,    0, 0, 4'd0,  C_MW, 15);
    add("fetch_tmo",  1, J,    0, 1, 4'd0,  C_FOK | C_BUS);
    add("tj_dec",     1, J,    0, 1, 4'd1,  C0);
    add("tj_jump",    1, J,    0, 1, 4'd11, C_PC);
    add("lwt_fetch",  1, LW,   0, 1, 4'd0,  C_FOK);
    add("lwt_dec",    1, LW,   0, 1, 4'd1,  C0);
    add("lwt_adr",    1, LW,   0, 1, 4'd2,  C0);
    add("lwt_wait",   1, LW,   0, 0, 4'd3,  C_MW, 16);
    add("lwt_abort",  1, SW,   0, 1, 4'd0,  C_FOK | C_BUS);
    add("swl_dec",    1, SW,   0, 1, 4'd1,  C0);
    add("swl_adr",    1, SW,   0, 1, 4'd2,  C0);
    add("swl_wait",   1, SW,   0, 0, 4'd5,  C_WR, 15);
    add("swl_last",   1, SW,   0, 1, 4'd5,  C_WR);
    add("swl_fetch",  1, RT,   0, 1, 4'd0,  C_FOK);
    add("rr_dec",     1, RT,   0, 1, 4'd1,  C0);
    add("rr_exe",     1, RT,   0, 1, 4'd6,  C0);
    add("rr_reset",   0, RT,   0, 1, 4'd0,  C0);
    add("rr_fetch",   1, RT,   0, 1, 4'd0,  C_FOK);
    add("rr_dec2",    1, RT,   0, 1, 4'd1,  C0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst; op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      sb.push_back(vecs[i]);
      #1;
      e = sb.pop_front();
      mux_e = e.rst ? mux_exp(e.st) : 10'd0;
      check("state", e.name, i, {6'd0, state}, {6'd0, e.st});
      check("ctl", e.name, i,
            {3'd0, mem_req, memwrite, irwrite, pcen, regwrite, illegal_op, bus_err},
            {3'd0, e.ctl});
      check("mux", e.name, i,
            {iord, regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop}, mux_e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Sequential control unit for the 32-bit multicycle variant of the RISC CPU: one shared ALU, one shared instruction/data memory, instruction and data latches in the datapath. A Moore FSM steps each instruction through fetch/decode/execute/memory/writeback, with a ready handshake on the memory port and a wait-state timeout. It drives the datapath muxes and enables and emits aluop for the existing ALU decoder.

Parameters:
TIMEOUT, 16, max cycles a memory state waits for mem_ready before abort; 0 disables the timeout.
STATE_W, 4, width of the debug state output.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
op  input  6  opcode field from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access requested
memwrite  output  1  access is a write
iord  output  1  memory address: 0 = PC, 1 = ALUOut
irwrite  output  1  load the instruction register
pcen  output  1  PC write enable
regwrite  output  1  register file write
regdst  output  1  destination: 0 = rt, 1 = rd
memtoreg  output  1  writeback data: 0 = ALUOut, 1 = data register
alusrca  output  1  ALU A: 0 = PC, 1 = rs data
alusrcb  output  2  ALU B: 00 = rt data, 01 = 4, 10 = signimm, 11 = signimm<<2
pcsrc  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
aluop  output  2  00 = add, 01 = sub, 10 = use funct
illegal_op  output  1  one-cycle pulse on an unknown opcode
bus_err  output  1  one-cycle pulse on a memory timeout
state  output  STATE_W  current state encoding (debug)

Behaviour:
- Reset: with rst_n=0 at a clock edge, state <= FETCH (0) and the wait counter clears. While rst_n=0, every output is forced to 0, including state. The first cycle after release is FETCH.
- Outputs are Moore, decoded from state, except three terms. irwrite/pcwrite in FETCH are qualified by mem_ready. pcen = pcwrite | (branch & zero). bus_err/illegal_op are registered pulses. Any output not listed in a state is 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 are unreachable; if entered, go to FETCH.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=pcwrite=mem_ready. Moves to DECODE on mem_ready, otherwise holds.
- DECODE: alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other op -> FETCH, with illegal_op pulsed the following cycle
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD if op=lw, else MEMWR.
- MEMRD: mem_req=1, iord=1. Goes to MEMWB on mem_ready, otherwise holds.
- MEMWB: regwrite=1, regdst=0, memtoreg=1 -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Goes to FETCH on mem_ready, otherwise holds.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- Latency with zero wait states (mem_ready=1 on the first request cycle): lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH/MEMRD/MEMWR and on every cycle mem_ready=1.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 with mem_ready=0, that edge moves to FETCH and bus_err pulses next cycle.
  - An aborted FETCH has done no pcwrite, so the same PC is refetched. An aborted lw does not write the register file. An aborted sw drops the write.
  - mem_ready on the timeout cycle wins: normal completion, no bus_err.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Reset asserted mid-instruction abandons it at the next edge. No register or memory write is issued while rst_n=0.

Test Plan:
1. Reset with rst_n=0 for 3 cycles, op=000000 -> all outputs 0 during reset; state=0 and mem_req=1 on the first cycle after release.
2. lw (op=100011), mem_ready always 1 -> states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. pcen=1 only in the FETCH cycle.
3. beq (op=000100): run once with zero=1, once with zero=0 -> state sequence 0,1,8,0 both times. In BRANCH, pcen=1 with pcsrc=01 when zero=1; pcen=0 when zero=0.
4. sw (op=101011) with mem_ready low for 3 cycles in MEMWR -> MEMWR held 4 cycles with memwrite=1. Then FETCH; no bus_err.
5. FETCH with mem_ready held 0 and TIMEOUT=16 -> 16 cycles in FETCH, then bus_err=1 for 1 cycle. irwrite and pcen stay 0 throughout; FETCH restarts.
6. Illegal op=111111 -> states 0,1,0; illegal_op=1 for exactly one cycle. No regwrite, memwrite or pcen outside FETCH.
